// File: rtl/pc_update_sequencer.sv
`default_nettype none
// ---- pc_update_sequencer: PC-source/PC/EPC write sequencer incl. exception entry ----
// ---- rev 1.0 | optional: PC_SEQ_CAUSE_REG_EN (cause / double_fault outputs)   ----
module pc_update_sequencer #(
  parameter int MEM_LAT  = 1,
  parameter int EXC_BASE = 253
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch_req,
  input  logic        branch_taken,
  input  logic        jump_req,
  input  logic        jr_req,
  input  logic        rte_req,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  output logic [2:0]  pcsource_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic        exc_mem_read,
  output logic [31:0] exc_addr,
  output logic        busy,
`ifdef PC_SEQ_CAUSE_REG_EN
  output logic [1:0]  cause,
  output logic        double_fault,
`endif
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UPDATE   = 3'd1,
    EXC_SAVE = 3'd2,
    EXC_WAIT = 3'd3,
    EXC_LOAD = 3'd4
  } state_t;

  localparam logic [2:0] SEL_ALU    = 3'b000;
  localparam logic [2:0] SEL_JUMP   = 3'b001;
  localparam logic [2:0] SEL_MEM    = 3'b010;
  localparam logic [2:0] SEL_ALUOUT = 3'b011;
  localparam logic [2:0] SEL_EPC    = 3'b100;
  localparam logic [2:0] WAIT_INIT  = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  state_t      state, state_next;
  logic [2:0]  wait_cnt, wait_cnt_next;
  logic [1:0]  cause_code, cause_next;
  logic [2:0]  upd_sel;
  logic        upd_pcw;
  logic        any_exc;

  logic [2:0]  sel_next;
  logic        pcw_next, epcw_next, mrd_next, busy_next, done_next;
  logic [31:0] addr_next;

  assign any_exc = exc_opcode | exc_overflow | exc_divzero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      cause_code   <= 2'd0;
      pcsource_sel <= SEL_ALU;
      pc_write     <= 1'b0;
      epc_write    <= 1'b0;
      exc_mem_read <= 1'b0;
      exc_addr     <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      wait_cnt     <= wait_cnt_next;
      cause_code   <= cause_next;
      pcsource_sel <= sel_next;
      pc_write     <= pcw_next;
      epc_write    <= epcw_next;
      exc_mem_read <= mrd_next;
      exc_addr     <= addr_next;
      busy         <= busy_next;
      done         <= done_next;
    end
  end

  // Next state plus the request decode latched for the UPDATE cycle.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    cause_next    = cause_code;
    upd_sel       = SEL_ALU;
    upd_pcw       = 1'b0;
    case (state)
      IDLE: begin
        if (any_exc) begin
          state_next = EXC_SAVE;
          cause_next = exc_opcode ? 2'd0 : (exc_overflow ? 2'd1 : 2'd2);
        end else if (rte_req) begin
          state_next = UPDATE;
          upd_sel    = SEL_EPC;
          upd_pcw    = 1'b1;
        end else if (jr_req) begin
          state_next = UPDATE;
          upd_sel    = SEL_ALU;
          upd_pcw    = 1'b1;
        end else if (jump_req) begin
          state_next = UPDATE;
          upd_sel    = SEL_JUMP;
          upd_pcw    = 1'b1;
        end else if (branch_req) begin
          state_next = UPDATE;
          upd_sel    = SEL_ALUOUT;
          upd_pcw    = branch_taken;
        end
      end
      UPDATE: state_next = IDLE;
      EXC_SAVE: begin
        if (MEM_LAT > 0) begin
          state_next    = EXC_WAIT;
          wait_cnt_next = WAIT_INIT;
        end else begin
          state_next = EXC_LOAD;
        end
      end
      EXC_WAIT: begin
        if (wait_cnt == 3'd0) state_next = EXC_LOAD;
        else wait_cnt_next = wait_cnt - 3'd1;
      end
      EXC_LOAD: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are a pure function of the state being entered, then registered.
  always_comb begin
    sel_next  = SEL_ALU;
    pcw_next  = 1'b0;
    epcw_next = 1'b0;
    mrd_next  = 1'b0;
    done_next = 1'b0;
    addr_next = 32'd0;
    busy_next = (state_next != IDLE);
    case (state_next)
      UPDATE: begin
        sel_next  = upd_sel;
        pcw_next  = upd_pcw;
        done_next = 1'b1;
      end
      EXC_SAVE: begin
        epcw_next = 1'b1;
        mrd_next  = 1'b1;
        addr_next = 32'(EXC_BASE) + 32'(cause_next);
      end
      EXC_WAIT: addr_next = exc_addr;
      EXC_LOAD: begin
        addr_next = exc_addr;
        sel_next  = SEL_MEM;
        pcw_next  = 1'b1;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PC_SEQ_CAUSE_REG_EN
  assign cause = cause_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      double_fault <= 1'b0;
    end else if (state == IDLE && !any_exc && rte_req) begin
      double_fault <= 1'b0;
    end else if ((state == EXC_SAVE || state == EXC_WAIT || state == EXC_LOAD) && any_exc) begin
      double_fault <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_update_sequencer.sv
`default_nettype none
// ---- tb_pc_update_sequencer: randomized + directed checks of two latency variants ----
module tb_pc_update_sequencer;
  localparam int BASE = 253;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic branch_req = 1'b0, branch_taken = 1'b0, jump_req = 1'b0, jr_req = 1'b0;
  logic rte_req = 1'b0, exc_opcode = 1'b0, exc_overflow = 1'b0, exc_divzero = 1'b0;

  logic [2:0]  sel1, sel0;
  logic        pcw1, pcw0, epcw1, epcw0, mrd1, mrd0, busy1, busy0, done1, done0;
  logic [31:0] addr1, addr0;
  logic [39:0] obs [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

`ifdef PC_SEQ_CAUSE_REG_EN
  logic [1:0] cause1, cause0;
  logic       df1, df0;
  logic [1:0] cause_exp = 2'd0;
  logic       df_exp = 1'b0;
`endif

  pc_update_sequencer #(.MEM_LAT(1), .EXC_BASE(BASE)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .branch_req(branch_req), .branch_taken(branch_taken),
    .jump_req(jump_req), .jr_req(jr_req), .rte_req(rte_req), .exc_opcode(exc_opcode),
    .exc_overflow(exc_overflow), .exc_divzero(exc_divzero), .pcsource_sel(sel1),
    .pc_write(pcw1), .epc_write(epcw1), .exc_mem_read(mrd1), .exc_addr(addr1), .busy(busy1),
`ifdef PC_SEQ_CAUSE_REG_EN
    .cause(cause1), .double_fault(df1),
`endif
    .done(done1));

  pc_update_sequencer #(.MEM_LAT(0), .EXC_BASE(BASE)) u_lat0 (
    .clk(clk), .reset_n(reset_n), .branch_req(branch_req), .branch_taken(branch_taken),
    .jump_req(jump_req), .jr_req(jr_req), .rte_req(rte_req), .exc_opcode(exc_opcode),
    .exc_overflow(exc_overflow), .exc_divzero(exc_divzero), .pcsource_sel(sel0),
    .pc_write(pcw0), .epc_write(epcw0), .exc_mem_read(mrd0), .exc_addr(addr0), .busy(busy0),
`ifdef PC_SEQ_CAUSE_REG_EN
    .cause(cause0), .double_fault(df0),
`endif
    .done(done0));

  assign obs[0] = {busy1, done1, pcw1, epcw1, mrd1, sel1, addr1};
  assign obs[1] = {busy0, done0, pcw0, epcw0, mrd0, sel0, addr0};

  // r = {exc_opcode, exc_overflow, exc_divzero, rte, jr, jump, branch}
  task automatic set_req(input logic [6:0] r, input logic t);
    {exc_opcode, exc_overflow, exc_divzero, rte_req, jr_req, jump_req, branch_req} = r;
    branch_taken = t;
  endtask

  // Expected outputs k cycles after the request edge, from the timeline rules.
  function automatic logic [39:0] expect_out(logic [6:0] r, logic t, int lat, int k);
    logic [2:0] sel; logic b, dn, pw, ew, mr; logic [31:0] a; int c;
    sel = 3'b000; b = 0; dn = 0; pw = 0; ew = 0; mr = 0; a = 0;
    if (r[6:4] != 3'b000) begin
      c = r[6] ? 0 : (r[5] ? 1 : 2);
      a = 32'(BASE + c);
      if (k == 1) begin b = 1; ew = 1; mr = 1; end
      else if (k <= 1 + lat) b = 1;
      else if (k == 2 + lat) begin b = 1; dn = 1; pw = 1; sel = 3'b010; end
      else a = 0;
    end else if (r[3:0] != 4'b0000 && k == 1) begin
      b = 1; dn = 1; pw = 1;
      if (r[3]) sel = 3'b100;
      else if (r[2]) sel = 3'b000;
      else if (r[1]) sel = 3'b001;
      else begin sel = 3'b011; pw = t; end
    end
    return {b, dn, pw, ew, mr, sel, a};
  endfunction

  // One request pulse, optional injected pulse on the first busy cycle, 4 cycles observed.
  task automatic run_txn(input string name, input logic [6:0] r, input logic t, input logic [6:0] inj);
    logic [39:0] exp;
    @(negedge clk);
    set_req(r, t);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) set_req(inj, 1'($urandom));
      else set_req(7'd0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        exp = expect_out(r, t, (d == 0) ? 1 : 0, k);
        total++;
        if (obs[d] !== exp) begin
          bad++;
          $display("FAIL %s lat=%0d cyc=%0d got=%h want=%h", name, (d == 0) ? 1 : 0, k, obs[d], exp);
        end
      end
    end
`ifdef PC_SEQ_CAUSE_REG_EN
    if (r[6:4] != 3'b000) begin
      cause_exp = r[6] ? 2'd0 : (r[5] ? 2'd1 : 2'd2);
      if (inj[6:4] != 3'b000) df_exp = 1'b1;
    end else if (r[3]) df_exp = 1'b0;
    total++;
    if ({cause1, df1, cause0, df0} !== {cause_exp, df_exp, cause_exp, df_exp}) begin
      bad++;
      $display("FAIL %s_cause_df got=%0d/%0d,%0d/%0d want=%0d/%0d", name, cause1, df1, cause0, df0, cause_exp, df_exp);
    end
`endif
  endtask

  task automatic test_reset;
    set_req(7'd0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== 40'd0) begin
        bad++;
        $display("FAIL reset_state dut=%0d got=%h want=0", d, obs[d]);
      end
    end
    reset_n = 1'b1;
    // Abort an exception mid-flight with an asynchronous reset.
    @(negedge clk); set_req(7'b0100000, 1'b0);
    @(negedge clk); set_req(7'd0, 1'b0);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== 40'd0) begin
        bad++;
        $display("FAIL reset_async dut=%0d got=%h want=0", d, obs[d]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
`ifdef PC_SEQ_CAUSE_REG_EN
    cause_exp = 2'd0; df_exp = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs[d] !== 40'd0) begin
          bad++;
          $display("FAIL reset_release dut=%0d cyc=%0d got=%h want=0", d, k, obs[d]);
        end
      end
    end
  endtask

  task automatic test_branch;
    run_txn("branch_taken", 7'b0000001, 1'b1, 7'd0);
    run_txn("branch_not_taken", 7'b0000001, 1'b0, 7'd0);
  endtask

  task automatic test_jr_jump;
    run_txn("jr_over_jump", 7'b0000110, 1'b0, 7'd0);
    run_txn("jump", 7'b0000010, 1'b0, 7'd0);
  endtask

  task automatic test_exceptions;
    run_txn("exc_overflow", 7'b0100000, 1'b0, 7'd0);
    run_txn("exc_divzero", 7'b0010000, 1'b0, 7'd0);
    run_txn("exc_all", 7'b1110000, 1'b0, 7'd0);
    run_txn("exc_over_rte", 7'b0011111, 1'b1, 7'd0);
  endtask

  task automatic test_nested;
    run_txn("nested_opcode", 7'b0010000, 1'b0, 7'b1000000);
    run_txn("rte_while_busy", 7'b0100000, 1'b0, 7'b0001000);
    run_txn("rte_idle", 7'b0001000, 1'b0, 7'd0);
  endtask

  task automatic test_random;
    logic [6:0] r, inj;
    for (int i = 0; i < 60; i++) begin
      r = 7'($urandom) & 7'($urandom);
      inj = (r == 7'd0) ? 7'd0 : 7'($urandom) & 7'($urandom);
      run_txn("random", r, 1'($urandom), inj);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jr_jump();
    test_exceptions();
    test_nested();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pc_update_sequencer.md
Name: pc_update_sequencer

Overview:
- Control FSM that drives the 5-input PC-source multiplexer (ALU result, jump address, zero-extended memory byte, ALUOut, EPC) plus the PC and EPC write enables.
- Sits between the main control unit and the PC/EPC registers.
- Sequences normal PC updates (branch, jump, jr, rte) and the multi-cycle exception entry: save EPC, read the handler byte from memory, load PC.

Parameters:
- MEM_LAT, 1, extra wait cycles between exception memory-read issue and data valid (0..7).
- EXC_BASE, 253, byte address of the first exception-vector entry. Vector address = EXC_BASE + cause code.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- branch_req  in  1  one-cycle pulse: conditional branch resolved this cycle
- branch_taken  in  1  branch condition, sampled with branch_req
- jump_req  in  1  pulse: j/jal target select
- jr_req  in  1  pulse: jr target from ALU result
- rte_req  in  1  pulse: return from exception
- exc_opcode  in  1  pulse: invalid opcode
- exc_overflow  in  1  pulse: arithmetic overflow
- exc_divzero  in  1  pulse: divide by zero
- pcsource_sel  out  3  mux select: 000 ALU result, 001 jump, 010 memory byte, 011 ALUOut, 100 EPC
- pc_write  out  1  PC register load enable
- epc_write  out  1  EPC register load enable
- exc_mem_read  out  1  memory read strobe for the vector fetch
- exc_addr  out  32  vector byte address
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse on the cycle the PC update is committed

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0; pcsource_sel = 000; wait counter = 0. Assertion mid-sequence aborts the sequence immediately, with no pending PC or EPC write.
- All outputs are registered and decoded from state only.
- Requests are sampled only in IDLE. Requests arriving while busy = 1 are ignored.
- Priority among simultaneous requests: exc_opcode > exc_overflow > exc_divzero > rte > jr > jump > branch. Lower-priority requests in the same cycle are dropped.
- Cause codes: opcode = 0, overflow = 1, divzero = 2.
- States:
  - IDLE: wait for a request. Normal request → UPDATE. Exception → EXC_SAVE.
  - UPDATE (1 cycle):
    - pcsource_sel = 011 for branch, 001 for jump, 000 for jr, 100 for rte.
    - pc_write = 1, except branch, where pc_write = latched branch_taken.
    - done = 1. Next state IDLE.
  - EXC_SAVE (1 cycle): epc_write = 1; exc_mem_read = 1; exc_addr = EXC_BASE + cause, zero-extended to 32 bits. Next state EXC_WAIT if MEM_LAT > 0, else EXC_LOAD.
  - EXC_WAIT: counter loads MEM_LAT-1 on entry and decrements. exc_addr is held. Exits to EXC_LOAD when the counter reaches 0.
  - EXC_LOAD (1 cycle): pcsource_sel = 010; pc_write = 1; done = 1. Next state IDLE.
- Latency, request edge to done: normal update 1 cycle; exception 2 + MEM_LAT cycles.
- A new exception during EXC_SAVE, EXC_WAIT or EXC_LOAD is ignored; no re-entry.
- Outside UPDATE and EXC_LOAD, pcsource_sel returns to 000 and pc_write = 0.
- exc_addr returns to 0 in IDLE.

Optional Feature:
- Macro: PC_SEQ_CAUSE_REG_EN.
- Defined: adds two outputs.
  - cause  out 2: registered cause code, loaded in EXC_SAVE, cleared by reset only.
  - double_fault  out 1: sticky; set if any exc_* pulse arrives while busy during an exception sequence; cleared by reset or by the rte_req UPDATE cycle.
- Undefined: neither port exists; nested exceptions are silently dropped.

Test Plan:
- Reset held low mid-EXC_WAIT, then released → all outputs 0, state IDLE; PC/EPC write never asserted after reset.
- branch_req = 1, branch_taken = 1 → next cycle pcsource_sel = 011, pc_write = 1, done = 1. Repeat with branch_taken = 0 → pc_write = 0, done = 1.
- jump_req and jr_req in the same cycle → pcsource_sel = 000 (jr wins), pc_write = 1 for exactly 1 cycle.
- exc_overflow with MEM_LAT = 1 → cycle 1: epc_write = 1, exc_mem_read = 1, exc_addr = 254. Cycle 2: wait. Cycle 3: pcsource_sel = 010, pc_write = 1, done = 1.
- exc_divzero with MEM_LAT = 0 → exc_addr = 255, done 2 cycles after the request. exc_opcode during EXC_SAVE → ignored; with PC_SEQ_CAUSE_REG_EN, cause = 2 and double_fault = 1.
- rte_req while busy → ignored. rte_req in IDLE → pcsource_sel = 100, pc_write = 1; double_fault cleared.
